// File: rtl/ascii_bcd_packer.sv
// ascii_bcd_packer
// Collects up to four ASCII decimal digits per number from a byte stream and
// emits one right-justified, zero-filled packed BCD word per number.
// Numbers close on the 4th digit, on TERM_CHAR, or on an idle timeout.
// An illegal byte poisons the number until the next terminator or timeout.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   in_data valid
//   in_ready   out  1   packer can accept a byte (low only while a word is pending)
//   in_data    in   8   ASCII byte
//   out_valid  out  1   out_bcd/out_ndig/out_err valid
//   out_ready  in   1   consumer accepts the word
//   out_bcd    out  16  packed BCD, most recent digit in [3:0]
//   out_ndig   out  3   digits captured (0..4)
//   out_err    out  1   word is erroneous (illegal byte or timeout)
//   err_count  out  8   saturating count of emitted error words
module ascii_bcd_packer #(
  parameter logic [7:0]  TERM_CHAR = 8'h0D,
  parameter int unsigned TO_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_bcd,
  output logic [2:0]  out_ndig,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StAcc, StSkip, StEmit} state_e;

  localparam logic       ToEnable = (TO_CYCLES != 0);
  // Only meaningful when the timeout is enabled.
  localparam logic [15:0] ToLast  = 16'(TO_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic [15:0] r_acc, w_acc_d;
  logic [2:0]  r_cnt, w_cnt_d;
  logic [15:0] r_to_cnt, w_to_cnt_d;
  logic [15:0] r_bcd, w_bcd_d;
  logic [2:0]  r_ndig, w_ndig_d;
  logic        r_err, w_err_d;
  logic [7:0]  r_err_count, w_err_count_d;

  logic       w_accept;
  logic       w_is_digit;
  logic       w_is_term;
  logic       w_timeout;
  logic [3:0] w_digit;

  assign in_ready   = (r_state != StEmit);
  assign out_valid  = (r_state == StEmit);
  assign out_bcd    = r_bcd;
  assign out_ndig   = r_ndig;
  assign out_err    = r_err;
  assign err_count  = r_err_count;

  assign w_accept   = in_valid & in_ready;
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign w_is_term  = (in_data == TERM_CHAR);
  assign w_digit    = in_data[3:0];
  // A byte accepted in the expiry cycle takes priority over the flush.
  assign w_timeout  = ToEnable && (r_to_cnt == ToLast) && !w_accept;

  always_comb begin
    w_state_d     = r_state;
    w_acc_d       = r_acc;
    w_cnt_d       = r_cnt;
    w_to_cnt_d    = r_to_cnt;
    w_bcd_d       = r_bcd;
    w_ndig_d      = r_ndig;
    w_err_d       = r_err;
    w_err_count_d = r_err_count;

    unique case (r_state)
      StIdle: begin
        w_to_cnt_d = 16'd0;
        if (w_accept) begin
          if (w_is_digit) begin
            w_acc_d   = {12'h000, w_digit};
            w_cnt_d   = 3'd1;
            w_state_d = StAcc;
          end else if (!w_is_term) begin
            w_state_d = StSkip;
          end
          // A bare terminator (empty line) is dropped.
        end
      end

      StAcc: begin
        if (w_accept) begin
          w_to_cnt_d = 16'd0;
          if (w_is_digit) begin
            w_acc_d = {r_acc[11:0], w_digit};
            w_cnt_d = r_cnt + 3'd1;
            if (r_cnt == 3'd3) begin
              w_bcd_d   = {r_acc[11:0], w_digit};
              w_ndig_d  = 3'd4;
              w_err_d   = 1'b0;
              w_state_d = StEmit;
            end
          end else if (w_is_term) begin
            w_bcd_d   = r_acc;
            w_ndig_d  = r_cnt;
            w_err_d   = 1'b0;
            w_state_d = StEmit;
          end else begin
            w_acc_d   = 16'd0;
            w_cnt_d   = 3'd0;
            w_state_d = StSkip;
          end
        end else if (w_timeout) begin
          w_to_cnt_d = 16'd0;
          w_bcd_d    = r_acc;
          w_ndig_d   = r_cnt;
          w_err_d    = 1'b1;
          w_state_d  = StEmit;
        end else if (ToEnable) begin
          w_to_cnt_d = r_to_cnt + 16'd1;
        end
      end

      StSkip: begin
        if (w_accept) begin
          w_to_cnt_d = 16'd0;
          if (w_is_term) begin
            w_bcd_d   = 16'd0;
            w_ndig_d  = 3'd0;
            w_err_d   = 1'b1;
            w_state_d = StEmit;
          end
        end else if (w_timeout) begin
          w_to_cnt_d = 16'd0;
          w_bcd_d    = 16'd0;
          w_ndig_d   = 3'd0;
          w_err_d    = 1'b1;
          w_state_d  = StEmit;
        end else if (ToEnable) begin
          w_to_cnt_d = r_to_cnt + 16'd1;
        end
      end

      StEmit: begin
        w_to_cnt_d = 16'd0;
        if (out_ready) begin
          w_acc_d   = 16'd0;
          w_cnt_d   = 3'd0;
          w_state_d = StIdle;
          if (r_err && (r_err_count != 8'hFF)) begin
            w_err_count_d = r_err_count + 8'd1;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_acc       <= 16'd0;
      r_cnt       <= 3'd0;
      r_to_cnt    <= 16'd0;
      r_bcd       <= 16'd0;
      r_ndig      <= 3'd0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_to_cnt    <= w_to_cnt_d;
      r_bcd       <= w_bcd_d;
      r_ndig      <= w_ndig_d;
      r_err       <= w_err_d;
      r_err_count <= w_err_count_d;
    end
  end

endmodule

// File: tb/tb_ascii_bcd_packer.sv
// Self-checking bench for ascii_bcd_packer (timeout shortened to 8 cycles).
module tb_ascii_bcd_packer;

  localparam logic [7:0] Cr = 8'h0D;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [2:0]  out_ndig;
  logic        out_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int exp_err_count = 0;

  // Captured words: {err, ndig, bcd}
  logic [19:0] rx_q[$];
  logic [7:0]  stim_q[$];
  logic [19:0] exp_q[$];

  ascii_bcd_packer #(
    .TERM_CHAR(8'h0D),
    .TO_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bcd  (out_bcd),
    .out_ndig (out_ndig),
    .out_err  (out_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge view matches the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) rx_q.push_back({out_err, out_ndig, out_bcd});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_byte: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_word(output logic ok, output logic [19:0] w);
    int n = 0;
    ok = 1'b0;
    w  = '0;
    while (rx_q.size() == 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rx_q.size() != 0) begin
      ok = 1'b1;
      w  = rx_q.pop_front();
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // Reference: turns a byte stream into expected words using plain list rules.
  task automatic model_stream();
    int digits[$];
    bit bad = 0;
    int v;
    exp_q.delete();
    foreach (stim_q[i]) begin
      if (bad) begin
        if (stim_q[i] == Cr) begin
          exp_q.push_back({1'b1, 3'd0, 16'd0});
          bad = 0;
        end
      end else if (stim_q[i] >= "0" && stim_q[i] <= "9") begin
        digits.push_back(int'(stim_q[i]) - 48);
        if (digits.size() == 4) begin
          v = 0;
          foreach (digits[k]) v = v * 16 + digits[k];
          exp_q.push_back({1'b0, 3'd4, v[15:0]});
          digits.delete();
        end
      end else if (stim_q[i] == Cr) begin
        if (digits.size() > 0) begin
          v = 0;
          foreach (digits[k]) v = v * 16 + digits[k];
          exp_q.push_back({1'b0, 3'(digits.size()), v[15:0]});
          digits.delete();
        end
      end else begin
        bad = 1;
        digits.delete();
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    if (out_bcd !== 16'h0) begin errors++; $display("FAIL reset_out_bcd: got %h want 0000", out_bcd); end
    if (out_ndig !== 3'd0) begin errors++; $display("FAIL reset_out_ndig: got %0d want 0", out_ndig); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_err_count = 0;
    idle(1);
    rx_q.delete();
  endtask

  task automatic test_four_digits();
    out_ready = 1'b1;
    rx_q.delete();
    send_byte("1");
    send_byte("2");
    send_byte("3");
    send_byte("4");
    // One cycle after the accepting edge of the 4th digit.
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL four_latency: out_valid=%0b want 1", out_valid); end
    if (out_bcd !== 16'h1234) begin errors++; $display("FAIL four_bcd: got %h want 1234", out_bcd); end
    if (out_ndig !== 3'd4) begin errors++; $display("FAIL four_ndig: got %0d want 4", out_ndig); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL four_err: got %0b want 0", out_err); end
    send_byte(Cr);
    idle(6);
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL four_then_cr: words=%0d want 1", rx_q.size());
    end
    rx_q.delete();
  endtask

  task automatic test_two_digits();
    logic ok;
    logic [19:0] w;
    out_ready = 1'b1;
    rx_q.delete();
    send_byte("4");
    send_byte("2");
    send_byte(Cr);
    wait_word(ok, w);
    checks++;
    if (!ok || w !== {1'b0, 3'd2, 16'h0042}) begin
      errors++;
      $display("FAIL two_digits: got ok=%0b word=%h want %h", ok, w, {1'b0, 3'd2, 16'h0042});
    end
  endtask

  task automatic test_skip_error();
    logic ok;
    logic [19:0] w;
    out_ready = 1'b1;
    rx_q.delete();
    send_byte("7");
    send_byte(8'h3A);
    send_byte("5");
    send_byte(Cr);
    wait_word(ok, w);
    exp_err_count = sat_add(exp_err_count, 1);
    idle(3);
    checks += 3;
    if (!ok || w !== {1'b1, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL skip_word: got ok=%0b word=%h want %h", ok, w, {1'b1, 3'd0, 16'h0000});
    end
    if (rx_q.size() != 0) begin errors++; $display("FAIL skip_single: extra=%0d want 0", rx_q.size()); end
    if (err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL skip_err_count: got %0d want %0d", err_count, exp_err_count);
    end
  endtask

  task automatic test_timeout();
    int k;
    logic ok;
    logic [19:0] w;
    out_ready = 1'b0;
    rx_q.delete();
    send_byte("9");
    k = 0;
    while (!out_valid && k < 20) begin
      idle(1);
      k++;
    end
    checks += 4;
    if (k != 8) begin errors++; $display("FAIL timeout_latency: cycles=%0d want 8", k); end
    if (out_bcd !== 16'h0009) begin errors++; $display("FAIL timeout_bcd: got %h want 0009", out_bcd); end
    if (out_ndig !== 3'd1) begin errors++; $display("FAIL timeout_ndig: got %0d want 1", out_ndig); end
    if (out_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %0b want 1", out_err); end
    out_ready = 1'b1;
    idle(1);
    exp_err_count = sat_add(exp_err_count, 1);
    out_ready = 1'b0;
    idle(1);
    rx_q.delete();
    // Second number: a byte lands on the expiry cycle and must win.
    send_byte("9");
    idle(7);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: out_valid=%0b want 0", out_valid); end
    send_byte("5");
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_race: out_valid=%0b want 0", out_valid); end
    out_ready = 1'b1;
    send_byte(Cr);
    wait_word(ok, w);
    checks++;
    if (!ok || w !== {1'b0, 3'd2, 16'h0095}) begin
      errors++;
      $display("FAIL timeout_race_word: got ok=%0b word=%h want %h", ok, w, {1'b0, 3'd2, 16'h0095});
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    logic ok;
    logic [19:0] w;
    out_ready = 1'b0;
    rx_q.delete();
    send_byte("8");
    send_byte("6");
    send_byte("1");
    send_byte("3");
    in_valid = 1'b1;
    in_data  = "5";
    for (int i = 0; i < 20; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bcd !== 16'h8613 ||
          out_ndig !== 3'd4 || out_err !== 1'b0) bad++;
      idle(1);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: unstable cycles=%0d want 0", bad); end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: out_valid=%0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: in_ready=%0b want 1", in_ready); end
    idle(1);
    in_valid = 1'b0;
    checks += 2;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL bp_one_handshake: words=%0d want 1", rx_q.size());
    end else begin
      w = rx_q.pop_front();
      if (w !== {1'b0, 3'd4, 16'h8613}) begin
        errors++;
        $display("FAIL bp_word: got %h want %h", w, {1'b0, 3'd4, 16'h8613});
      end
    end
    out_ready = 1'b1;
    send_byte(Cr);
    wait_word(ok, w);
    checks++;
    if (!ok || w !== {1'b0, 3'd1, 16'h0005}) begin
      errors++;
      $display("FAIL bp_next_byte: got ok=%0b word=%h want %h", ok, w, {1'b0, 3'd1, 16'h0005});
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [19:0] w;
    out_ready = 1'b1;
    rx_q.delete();
    send_byte("1");
    send_byte("2");
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %0b want 1", in_ready); end
    if (out_bcd !== 16'h0) begin errors++; $display("FAIL rmid_out_bcd: got %h want 0000", out_bcd); end
    if (out_ndig !== 3'd0) begin errors++; $display("FAIL rmid_out_ndig: got %0d want 0", out_ndig); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL rmid_out_err: got %0b want 0", out_err); end
    if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_err_count: got %0d want 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_err_count = 0;
    idle(1);
    send_byte("3");
    send_byte(Cr);
    wait_word(ok, w);
    checks++;
    if (!ok || w !== {1'b0, 3'd1, 16'h0003}) begin
      errors++;
      $display("FAIL rmid_after: got ok=%0b word=%h want %h", ok, w, {1'b0, 3'd1, 16'h0003});
    end
  endtask

  task automatic test_random();
    int nerr = 0;
    int n;
    int kind;
    int bad = 0;
    bit done = 0;
    logic [19:0] w;
    stim_q.delete();
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) stim_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        if (n < 4 || $urandom_range(0, 1) == 1) stim_q.push_back(Cr);
      end else if (kind <= 7) begin
        stim_q.push_back(Cr);
      end else begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) stim_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
        if ($urandom_range(0, 1) == 1) stim_q.push_back(8'($urandom_range(8'h3A, 8'h3F)));
        else stim_q.push_back(8'($urandom_range(8'h41, 8'h5A)));
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) stim_q.push_back(8'($urandom_range(8'h30, 8'h5A)));
        stim_q.push_back(Cr);
      end
    end
    model_stream();
    rx_q.delete();
    fork
      begin
        foreach (stim_q[i]) begin
          send_byte(stim_q[i]);
          idle($urandom_range(0, 3));
        end
        idle(20);
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          idle(1);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (rx_q.size() < exp_q.size() && n < 200) begin
      idle(1);
      n++;
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: words=%0d want %0d", rx_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (exp_q[i][19]) nerr++;
      if (rx_q.size() != 0) begin
        w = rx_q.pop_front();
        checks++;
        if (w !== exp_q[i]) begin
          errors++;
          bad++;
          if (bad <= 5) $display("FAIL rand_word[%0d]: got %h want %h", i, w, exp_q[i]);
        end
      end
    end
    exp_err_count = sat_add(exp_err_count, nerr);
    checks++;
    if (err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL rand_err_count: got %0d want %0d", err_count, exp_err_count);
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    out_ready = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 260; i++) begin
      send_byte(8'h3A);
      send_byte(Cr);
    end
    idle(4);
    exp_err_count = sat_add(exp_err_count, 260);
    checks += 3;
    if (rx_q.size() != 260) begin errors++; $display("FAIL sat_words: got %0d want 260", rx_q.size()); end
    foreach (rx_q[i]) if (rx_q[i] !== {1'b1, 3'd0, 16'h0000}) bad++;
    if (bad != 0) begin errors++; $display("FAIL sat_word_vals: wrong=%0d want 0", bad); end
    if (err_count !== 8'(exp_err_count)) begin
      errors++;
      $display("FAIL sat_err_count: got %0d want %0d", err_count, exp_err_count);
    end
  endtask

  initial begin
    test_reset();
    test_four_digits();
    test_two_digits();
    test_skip_error();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
